// File: rtl/regfile_sb.sv
// regfile_sb: register file with x0 hardwired to zero, a per-register pending-write scoreboard and optional write-to-read bypass
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             issue,
    input  logic [AW-1:0]    issue_addr,
    output logic [AW:0]      pending_cnt
);
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic wr, iss, inc, dec, fwd1, fwd2, clr1, clr2;
    always_comb begin
        wr = we && rd_addr != '0;
        iss = issue && issue_addr != '0;
        inc = iss && !busy[issue_addr];
        dec = wr && busy[rd_addr] && !(iss && issue_addr == rd_addr);
        fwd1 = BYPASS != 0 && wr && rs1_addr == rd_addr;
        fwd2 = BYPASS != 0 && wr && rs2_addr == rd_addr;
        // a forwarded write hides the busy bit unless the same cycle re-issues that register
        clr1 = fwd1 && !(iss && issue_addr == rs1_addr);
        clr2 = fwd2 && !(iss && issue_addr == rs2_addr);
        rs1_data = rs1_addr == '0 ? '0 : fwd1 ? rd_data : regs[rs1_addr];
        rs2_data = rs2_addr == '0 ? '0 : fwd2 ? rd_data : regs[rs2_addr];
        rs1_busy = rs1_addr != '0 && !clr1 && busy[rs1_addr];
        rs2_busy = rs2_addr != '0 && !clr2 && busy[rs2_addr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
            pending_cnt <= '0;
        end else begin
            if (wr) begin
                regs[rd_addr] <= rd_data;
                busy[rd_addr] <= 1'b0;
            end
            if (iss) busy[issue_addr] <= 1'b1;
            pending_cnt <= pending_cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against an array-based reference model, bypass and non-bypass instances side by side
module tb_regfile_sb;
    localparam int W = 32;
    localparam int D = 32;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic rst, we, issue;
    logic [AW-1:0] rd_addr, rs1_addr, rs2_addr, issue_addr;
    logic [W-1:0] rd_data, rs1_data, rs2_data, nb1_data, nb2_data;
    logic rs1_busy, rs2_busy, nb1_busy, nb2_busy;
    logic [AW:0] pending_cnt, nb_cnt;
    int errors = 0;
    int checks = 0;
    logic [W-1:0] m_reg [D];
    bit m_busy [D];

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue(issue), .issue_addr(issue_addr),
        .pending_cnt(pending_cnt)
    );

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb1_data), .rs2_data(nb2_data),
        .rs1_busy(nb1_busy), .rs2_busy(nb2_busy), .issue(issue), .issue_addr(issue_addr),
        .pending_cnt(nb_cnt)
    );

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [W-1:0] e_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we && rd_addr != 0 && rd_addr == a) return rd_data;
        return m_reg[a];
    endfunction

    function automatic logic e_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && we && rd_addr == a && a != 0 && !(issue && issue_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle();
        rst = 0; we = 0; issue = 0; rd_addr = '0; rd_data = '0;
        issue_addr = '0; rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < D; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
        end else begin
            if (we && rd_addr != 0) begin m_reg[rd_addr] = rd_data; m_busy[rd_addr] = 0; end
            if (issue && issue_addr != 0) m_busy[issue_addr] = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; we = 1; rd_addr = 5'd3; rd_data = 32'hA5A5A5A5; issue = 1; issue_addr = 5'd3;
        clock_edge();
        idle();
        for (int a = 0; a < D; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(D - 1 - a);
            #1;
            checks++;
            if ({rs1_data, rs2_data, nb1_data, nb2_data} !== '0) begin
                errors++; $display("FAIL reset_data a=%0d: got %h %h want 0", a, rs1_data, rs2_data);
            end
            checks++;
            if ({rs1_busy, rs2_busy, nb1_busy, nb2_busy} !== 4'b0) begin
                errors++; $display("FAIL reset_busy a=%0d: got %b%b want 00", a, rs1_busy, rs2_busy);
            end
        end
        checks++;
        if (pending_cnt !== 6'd0 || nb_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt);
        end
        clock_edge();
    endtask

    task automatic test_bypass();
        idle(); we = 1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #4;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rs1_data);
        end
        checks++;
        if (nb1_data !== 32'h0) begin
            errors++; $display("FAIL nobypass_same_cycle: got %h want 0", nb1_data);
        end
        clock_edge();
        idle(); rs1_addr = 5'd5;
        #4;
        checks++;
        if (nb1_data !== 32'hDEADBEEF || rs1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_next_cycle: got %h/%h want deadbeef", rs1_data, nb1_data);
        end
        clock_edge();
    endtask

    task automatic test_scoreboard();
        idle(); issue = 1; issue_addr = 5'd3;
        #4;
        checks++;
        if (pending_cnt !== 6'd0) begin errors++; $display("FAIL sb_cnt0: got %0d want 0", pending_cnt); end
        clock_edge();
        idle(); issue = 1; issue_addr = 5'd7; rs1_addr = 5'd3;
        #4;
        checks++;
        if (pending_cnt !== 6'd1 || rs1_busy !== 1'b1) begin
            errors++; $display("FAIL sb_issue3: got cnt=%0d busy=%b want 1/1", pending_cnt, rs1_busy);
        end
        clock_edge();
        idle(); we = 1; rd_addr = 5'd3; rd_data = 32'h33; rs1_addr = 5'd3; rs2_addr = 5'd7;
        #4;
        checks++;
        if (pending_cnt !== 6'd2 || rs2_busy !== 1'b1) begin
            errors++; $display("FAIL sb_issue7: got cnt=%0d busy7=%b want 2/1", pending_cnt, rs2_busy);
        end
        checks++;
        if (rs1_busy !== 1'b0 || nb1_busy !== 1'b1) begin
            errors++; $display("FAIL sb_busy_bypass: got %b/%b want 0/1", rs1_busy, nb1_busy);
        end
        clock_edge();
        idle(); rs1_addr = 5'd3;
        #4;
        checks++;
        if (pending_cnt !== 6'd1 || rs1_busy !== 1'b0 || nb1_busy !== 1'b0 || rs1_data !== 32'h33) begin
            errors++; $display("FAIL sb_write3: got cnt=%0d busy=%b data=%h want 1/0/33", pending_cnt, rs1_busy, rs1_data);
        end
        clock_edge();
    endtask

    task automatic test_issue_write_same();
        idle(); issue = 1; issue_addr = 5'd4;
        clock_edge();
        idle(); issue = 1; issue_addr = 5'd4; we = 1; rd_addr = 5'd4; rd_data = 32'h11; rs1_addr = 5'd4;
        #4;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_data !== 32'h11 || pending_cnt !== 6'd2) begin
            errors++; $display("FAIL same_pre: got busy=%b data=%h cnt=%0d want 1/11/2", rs1_busy, rs1_data, pending_cnt);
        end
        clock_edge();
        idle(); issue = 1; issue_addr = 5'd4; rs1_addr = 5'd4;
        #4;
        checks++;
        if (rs1_busy !== 1'b1 || nb1_data !== 32'h11 || pending_cnt !== 6'd2) begin
            errors++; $display("FAIL same_post: got busy=%b data=%h cnt=%0d want 1/11/2", rs1_busy, nb1_data, pending_cnt);
        end
        clock_edge();
        idle(); issue = 1; issue_addr = 5'd6; we = 1; rd_addr = 5'd6; rd_data = 32'h66;
        #4;
        checks++;
        if (pending_cnt !== 6'd2) begin errors++; $display("FAIL reissue_busy: got %0d want 2", pending_cnt); end
        clock_edge();
        idle(); rs2_addr = 5'd6;
        #4;
        checks++;
        if (pending_cnt !== 6'd3 || rs2_busy !== 1'b1 || rs2_data !== 32'h66) begin
            errors++; $display("FAIL same_fresh: got cnt=%0d busy=%b data=%h want 3/1/66", pending_cnt, rs2_busy, rs2_data);
        end
        clock_edge();
    endtask

    task automatic test_zero();
        idle(); we = 1; rd_addr = '0; rd_data = 32'hFFFFFFFF; issue = 1; issue_addr = '0;
        #4;
        checks++;
        if (rs1_data !== 32'h0 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL zero_same: got %h/%b want 0/0", rs1_data, rs1_busy);
        end
        clock_edge();
        idle();
        #4;
        checks++;
        if (rs1_data !== 32'h0 || nb2_data !== 32'h0 || rs1_busy !== 1'b0 || pending_cnt !== 6'd3) begin
            errors++; $display("FAIL zero_after: got %h/%b cnt=%0d want 0/0/3", rs1_data, rs1_busy, pending_cnt);
        end
        clock_edge();
    endtask

    task automatic test_reset_priority();
        idle(); issue = 1; issue_addr = 5'd1; clock_edge();
        issue_addr = 5'd2; clock_edge();
        issue_addr = 5'd9; clock_edge();
        idle();
        #4;
        checks++;
        if (pending_cnt !== 6'd6) begin errors++; $display("FAIL rstp_pre: got %0d want 6", pending_cnt); end
        rst = 1; we = 1; rd_addr = 5'd2; rd_data = 32'h22; issue = 1; issue_addr = 5'd10;
        clock_edge();
        idle(); rs1_addr = 5'd2; rs2_addr = 5'd9;
        #4;
        checks++;
        if (pending_cnt !== 6'd0 || nb_cnt !== 6'd0 || rs1_data !== 32'h0 || nb1_data !== 32'h0) begin
            errors++; $display("FAIL rstp_state: got cnt=%0d reg2=%h want 0/0", pending_cnt, nb1_data);
        end
        checks++;
        if ({rs1_busy, rs2_busy, nb1_busy, nb2_busy} !== 4'b0) begin
            errors++; $display("FAIL rstp_busy: got %b%b%b%b want 0000", rs1_busy, rs2_busy, nb1_busy, nb2_busy);
        end
        clock_edge();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            int lim;
            lim = ($urandom_range(1) == 1) ? 7 : 31;
            rst = ($urandom_range(63) == 0);
            we = !rst && ($urandom_range(1) == 1);
            issue = !rst && ($urandom_range(2) == 0);
            rd_addr = AW'($urandom_range(lim));
            issue_addr = AW'($urandom_range(lim));
            rs1_addr = AW'($urandom_range(lim));
            rs2_addr = ($urandom_range(3) == 0) ? rs1_addr : AW'($urandom_range(lim));
            rd_data = $urandom();
            #4;
            checks++;
            if (rs1_data !== e_data(rs1_addr, 1) || rs2_data !== e_data(rs2_addr, 1)) begin
                errors++; $display("FAIL rand_data n=%0d: got %h %h want %h %h", n, rs1_data, rs2_data, e_data(rs1_addr, 1), e_data(rs2_addr, 1));
            end
            checks++;
            if (nb1_data !== e_data(rs1_addr, 0) || nb2_data !== e_data(rs2_addr, 0)) begin
                errors++; $display("FAIL rand_nb_data n=%0d: got %h %h want %h %h", n, nb1_data, nb2_data, e_data(rs1_addr, 0), e_data(rs2_addr, 0));
            end
            checks++;
            if (rs1_busy !== e_busy(rs1_addr, 1) || rs2_busy !== e_busy(rs2_addr, 1)) begin
                errors++; $display("FAIL rand_busy n=%0d: got %b%b want %b%b", n, rs1_busy, rs2_busy, e_busy(rs1_addr, 1), e_busy(rs2_addr, 1));
            end
            checks++;
            if (nb1_busy !== e_busy(rs1_addr, 0) || nb2_busy !== e_busy(rs2_addr, 0)) begin
                errors++; $display("FAIL rand_nb_busy n=%0d: got %b%b want %b%b", n, nb1_busy, nb2_busy, e_busy(rs1_addr, 0), e_busy(rs2_addr, 0));
            end
            checks++;
            if (pending_cnt !== (AW+1)'(m_cnt()) || nb_cnt !== (AW+1)'(m_cnt())) begin
                errors++; $display("FAIL rand_cnt n=%0d: got %0d/%0d want %0d", n, pending_cnt, nb_cnt, m_cnt());
            end
            clock_edge();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_issue_write_same();
        test_zero();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each register.
REQ-002 SHALL have parameter DEPTH, default 32, meaning register count (power of two, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding enabled.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port rd_addr  input  AW  write address.
REQ-008 SHALL have port rd_data  input  WIDTH  write data.
REQ-009 SHALL have port rs1_addr / rs2_addr  input  AW  read addresses.
REQ-010 SHALL have port rs1_data / rs2_data  output  WIDTH  read data.
REQ-011 SHALL have port rs1_busy / rs2_busy  output  1  source register has a pending write.
REQ-012 SHALL have port issue  input  1  mark register issue_addr as pending.
REQ-013 SHALL have port issue_addr  input  AW  destination register being issued.
REQ-014 SHALL have port pending_cnt  output  AW+1  number of registers currently marked pending.

Function
REQ-015 SHALL hold register 0 at zero; writes and issues to address 0 SHALL be ignored.
REQ-016 SHALL, on a rising clk edge with we=1 and rd_addr!=0, store rd_data into register rd_addr.
REQ-017 SHALL read combinationally: rsN_data = register[rsN_addr], or 0 when rsN_addr==0.
REQ-018 SHALL, when BYPASS=1, we=1, rd_addr!=0 and rsN_addr==rd_addr, drive rsN_data = rd_data in the same cycle.
REQ-019 SHALL keep one busy bit per register; issue=1 with issue_addr!=0 sets busy[issue_addr] at the clock edge.
REQ-020 SHALL clear busy[rd_addr] at the clock edge when we=1 and rd_addr!=0, unless it is re-set in the same cycle.
REQ-021 SHALL, for issue and we to the same nonzero address in one cycle, store rd_data and leave busy set (issue wins).
REQ-022 SHALL treat a write to a non-busy register as a plain write; busy stays clear.
REQ-023 SHALL treat issue to an already-busy register as no change to busy or pending_cnt.
REQ-024 SHALL drive rsN_busy = busy[rsN_addr], 0 for address 0; when BYPASS=1 and a same-cycle write clears that register, rsN_busy SHALL read 0.
REQ-025 SHALL update pending_cnt by registered counting: +1 on each 0->1 busy transition, -1 on each 1->0, net 0 when both occur in one cycle.
REQ-026 SHALL keep pending_cnt equal to the popcount of busy at every clock edge; it never exceeds DEPTH-1.
REQ-027 SHALL support rs1_addr==rs2_addr, with both ports returning identical data and busy.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, clear all registers to 0, clear all busy bits and set pending_cnt to 0.
REQ-029 SHALL give rst priority over we and issue in the same cycle; a write or issue during reset is discarded.
REQ-030 SHALL, after reset, drive rsN_data=0, rsN_busy=0 and pending_cnt=0 until the first accepted write or issue.

Verification
REQ-031 Reset, then read all addresses -> every rsN_data=0, busy=0, pending_cnt=0.
REQ-032 we=1, rd_addr=5, rd_data=0xDEADBEEF, rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF that cycle with BYPASS=1, next cycle with BYPASS=0.
REQ-033 issue x3, then issue x7 -> pending_cnt 1 then 2; write x3 -> rs1_busy(x3)=0, pending_cnt=1.
REQ-034 Same cycle: issue=1/issue_addr=4 and we=1/rd_addr=4/rd_data=0x11 -> reg4=0x11, busy[4]=1, pending_cnt unchanged if already busy.
REQ-035 we=1, rd_addr=0, rd_data=0xFFFFFFFF, issue x0 -> rs1_data(x0)=0, busy=0, pending_cnt unchanged.
REQ-036 Issue x1, x2, x9, then assert rst together with we to x2 -> all busy cleared, pending_cnt=0, reg2=0.
